keypad_emu: RTL and testbench

- Synthesizable responder for the 4x3 matrix keypad interface driven by key_scan.
- key_scan drives rows active-low and senses columns. This block watches the row drives and pulls the matching column low, as a physical key closure would.
- Used for bench and board self-test: a command port injects timed presses of phone-keypad keys, and the scanner's key code output can be checked end to end.

---
 rtl/keypad_pkg.sv | 54 +++++
 rtl/keypad_emu.sv | 148 ++++++++++++++
 tb/tb_keypad_emu.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 phone keypad: key codes, responder states
// and the code-to-matrix-position decode (also usable by the scanner side).
package keypad_pkg;

  localparam logic [4:0] KEY_NONE = 5'h00;
  localparam logic [4:0] KEY_0    = 5'h10;
  localparam logic [4:0] KEY_1    = 5'h11;
  localparam logic [4:0] KEY_2    = 5'h12;
  localparam logic [4:0] KEY_3    = 5'h13;
  localparam logic [4:0] KEY_4    = 5'h14;
  localparam logic [4:0] KEY_5    = 5'h15;
  localparam logic [4:0] KEY_6    = 5'h16;
  localparam logic [4:0] KEY_7    = 5'h17;
  localparam logic [4:0] KEY_8    = 5'h18;
  localparam logic [4:0] KEY_9    = 5'h19;
  localparam logic [4:0] KEY_STAR = 5'h1A;
  localparam logic [4:0] KEY_HASH = 5'h1B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BOUNCE,
    S_PRESS,
    S_GAP
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Column index is the col_n bit: the left keypad column is bit 2.
  function automatic key_pos_t key_decode(input logic [4:0] code);
    key_pos_t p;
    p = '{1'b0, 2'd0, 2'd0};
    case (code)
      KEY_1:    p = '{1'b1, 2'd0, 2'd2};
      KEY_2:    p = '{1'b1, 2'd0, 2'd1};
      KEY_3:    p = '{1'b1, 2'd0, 2'd0};
      KEY_4:    p = '{1'b1, 2'd1, 2'd2};
      KEY_5:    p = '{1'b1, 2'd1, 2'd1};
      KEY_6:    p = '{1'b1, 2'd1, 2'd0};
      KEY_7:    p = '{1'b1, 2'd2, 2'd2};
      KEY_8:    p = '{1'b1, 2'd2, 2'd1};
      KEY_9:    p = '{1'b1, 2'd2, 2'd0};
      KEY_STAR: p = '{1'b1, 2'd3, 2'd2};
      KEY_0:    p = '{1'b1, 2'd3, 2'd1};
      KEY_HASH: p = '{1'b1, 2'd3, 2'd0};
      default:  p = '{1'b0, 2'd0, 2'd0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/keypad_emu.sv
// Keypad responder: injects timed key closures into a row-scanned 4x3 matrix,
// pulling the selected column low only while the scanner drives its row.
module keypad_emu
  import keypad_pkg::*;
#(
  parameter int HOLD_W        = 16,
  parameter int GAP_CYCLES    = 8192,
  parameter int BOUNCE_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        row_n,
  output logic [2:0]        col_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int BNC_W = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES + 1) : 1;

  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BNC_W-1:0]  BNC_ONE  = BNC_W'(1);
  localparam logic [BNC_W-1:0]  BNC_LAST = BNC_W'(BOUNCE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [4:0]        key_q, key_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [BNC_W-1:0]  bnc_q, bnc_d;
  logic [2:0]        col_n_q, col_n_d;
  logic              rdy_q;
  logic              done_q, done_d;
  logic              err_q, err_d;

  key_pos_t cmd_pos;
  key_pos_t cur_pos;
  logic     accept;
  logic     closed;

  assign cmd_pos = key_decode(cmd_key);
  assign cur_pos = key_decode(key_q);
  assign accept  = cmd_valid && rdy_q;

  // Chatter alternates closed/open, starting closed on the first bounce cycle.
  assign closed = (state_q == S_PRESS) || ((state_q == S_BOUNCE) && !bnc_q[0]);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    bnc_d   = bnc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!cmd_pos.valid) begin
            err_d = 1'b1;
          end else begin
            key_d   = cmd_key;
            hold_d  = (cmd_hold == '0) ? HOLD_ONE : cmd_hold;
            gap_d   = '0;
            bnc_d   = '0;
            state_d = (BOUNCE_CYCLES > 0) ? S_BOUNCE : S_PRESS;
          end
        end
      end
      S_BOUNCE: begin
        if (bnc_q == BNC_LAST) begin
          bnc_d   = '0;
          state_d = S_PRESS;
        end else begin
          bnc_d = bnc_q + BNC_ONE;
        end
      end
      S_PRESS: begin
        if (hold_q <= HOLD_ONE) begin
          hold_d  = '0;
          state_d = S_GAP;
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Passive switch: only the latched key's row can close its column.
  always_comb begin
    col_n_d = 3'b111;
    if (closed && !row_n[cur_pos.row]) begin
      case (cur_pos.col)
        2'd0:    col_n_d = 3'b110;
        2'd1:    col_n_d = 3'b101;
        2'd2:    col_n_d = 3'b011;
        default: col_n_d = 3'b111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      key_q   <= KEY_NONE;
      hold_q  <= '0;
      gap_q   <= '0;
      bnc_q   <= '0;
      col_n_q <= 3'b111;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      bnc_q   <= bnc_d;
      col_n_q <= col_n_d;
      rdy_q   <= (state_d == S_IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign col_n     = col_n_q;
  assign cmd_ready = rdy_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_keypad_emu.sv
// Randomized scoreboard bench for keypad_emu: two instances (no chatter and
// 16-cycle chatter) share stimulus and are checked against a timeline model.
module tb_keypad_emu;

  localparam int HOLD_W = 16;
  localparam int GAP    = 64;
  localparam int BNC1   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [3:0]        row_n = 4'hF;
  logic              cmd_valid = 1'b0;
  logic [4:0]        cmd_key = 5'h00;
  logic [HOLD_W-1:0] cmd_hold = '0;

  logic [2:0] col0, col1;
  logic       rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;

  keypad_emu #(.HOLD_W(HOLD_W), .GAP_CYCLES(GAP), .BOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .row_n(row_n), .col_n(col0),
    .cmd_valid(cmd_valid), .cmd_ready(rdy0), .cmd_key(cmd_key), .cmd_hold(cmd_hold),
    .busy(busy0), .done(done0), .err(err0)
  );

  keypad_emu #(.HOLD_W(HOLD_W), .GAP_CYCLES(GAP), .BOUNCE_CYCLES(BNC1)) dut1 (
    .clk(clk), .reset(reset), .row_n(row_n), .col_n(col1),
    .cmd_valid(cmd_valid), .cmd_ready(rdy1), .cmd_key(cmd_key), .cmd_hold(cmd_hold),
    .busy(busy1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  // Phone layout, rows top to bottom; entry j of a row drives col_n bit 2-j.
  logic [4:0] keymap [4][3] = '{'{5'h11, 5'h12, 5'h13},
                                '{5'h14, 5'h15, 5'h16},
                                '{5'h17, 5'h18, 5'h19},
                                '{5'h1A, 5'h10, 5'h1B}};
  logic [4:0] badkeys [8] = '{5'h1C, 5'h00, 5'h0F, 5'h1F, 5'h01, 5'h1D, 5'h1E, 5'h0B};

  int         cyc = 0;
  logic [3:0] row_at_edge = 4'hF;
  logic       rst_at_edge = 1'b0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    row_at_edge <= row_n;
    rst_at_edge <= reset;
    if (reset) chk_en <= 1'b1;
  end

  bit m_active = 1'b0;
  int m_A = 0;
  int m_h = 1;
  int m_row = 0;
  int m_col = 0;
  int m_kill = 32'h7fffffff;

  int errors = 0;
  int checks = 0;
  int q0[$];
  int q1[$];

  function automatic void kp_pos(input logic [4:0] k, output bit v, output int r, output int c);
    v = 1'b0; r = 0; c = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++)
        if (keymap[i][j] == k) begin v = 1'b1; r = i; c = 2 - j; end
  endfunction

  // 0 idle, 1 chatter closed, 2 chatter open, 3 press, 4 gap (state after edge e)
  function automatic int phase(input int d, input int e);
    int b, x;
    b = (d == 0) ? 0 : BNC1;
    if (!m_active || e < m_A || e >= m_kill) return 0;
    x = e - m_A;
    if (x < b) return (x % 2 == 0) ? 1 : 2;
    if (x < b + m_h) return 3;
    if (x < b + m_h + GAP) return 4;
    return 0;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction
  function automatic int qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction
  function automatic int qpop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic check(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, d, cyc, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic [2:0] col, input logic rdy, input logic bsy,
                     input logic dn, input logic er);
    int e, p, pp, ec, ev;
    e  = cyc;
    p  = phase(d, e);
    pp = phase(d, e - 1);
    ec = 7;
    if (!rst_at_edge && (pp == 1 || pp == 3) && !row_at_edge[m_row]) ec = 7 & ~(1 << m_col);
    check("col_n", d, int'(col), ec);
    check("cmd_ready", d, int'(rdy), int'(!rst_at_edge && p == 0));
    check("busy", d, int'(bsy), int'(!rst_at_edge && p != 0));
    while (qsize(d) > 0 && qfront(d) / 2 < e) begin
      ev = qpop(d);
      checks++;
      errors++;
      $display("FAIL missed_pulse dut%0d: none by cycle %0d, expected %s at cycle %0d",
               d, e, (ev % 2) ? "err" : "done", ev / 2);
    end
    if (dn || er) begin
      if (qsize(d) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse dut%0d cycle %0d: done=%0b err=%0b, expected none", d, e, dn, er);
      end else begin
        ev = qpop(d);
        check("pulse_cycle", d, e, ev / 2);
        check("done", d, int'(dn), int'(ev % 2 == 0));
        check("err", d, int'(er), ev % 2);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      mon(0, col0, rdy0, busy0, done0, err0);
      mon(1, col1, rdy1, busy1, done1, err1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset  = 1'b1;
    m_kill = cyc + 1;
    q0.delete();
    q1.delete();
    repeat (n) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic issue(input logic [4:0] k, input int h, input bit wait_idle);
    bit v;
    int r, c, a, hh, dend;
    kp_pos(k, v, r, c);
    a  = cyc + 1;
    hh = (h == 0) ? 1 : h;
    cmd_key   = k;
    cmd_hold  = HOLD_W'(h);
    cmd_valid = 1'b1;
    if (v) begin
      m_active = 1'b1; m_A = a; m_h = hh; m_row = r; m_col = c; m_kill = 32'h7fffffff;
      q0.push_back((a + hh + GAP) * 2);
      q1.push_back((a + BNC1 + hh + GAP) * 2);
    end else begin
      q0.push_back(a * 2 + 1);
      q1.push_back(a * 2 + 1);
    end
    tick();
    if (v) begin
      // requests while busy must be ignored, not queued
      repeat (3) begin
        cmd_key  = 5'($urandom);
        cmd_hold = HOLD_W'($urandom);
        tick();
      end
    end
    cmd_valid = 1'b0;
    if (v && wait_idle) begin
      dend = a + BNC1 + hh + GAP;
      while (cyc < dend) tick();
    end
  endtask

  // Scanner stand-in: mostly a slow one-row-low sweep, sometimes idle or garbage.
  initial begin
    int scan, sub, m;
    scan = 0;
    sub  = 0;
    forever begin
      tick();
      sub++;
      if (sub == 4) begin
        sub  = 0;
        scan = (scan + 1) % 4;
      end
      m = $urandom_range(0, 9);
      if (m < 7)       row_n = 4'hF & ~(4'h1 << scan);
      else if (m == 7) row_n = 4'hF;
      else             row_n = 4'($urandom);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    do_reset(4);
    repeat (3) tick();

    issue(5'h15, 20000, 1'b1);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++)
        issue(keymap[i][j], (i * 3 + j == 3) ? 0 : ((i * 3 + j == 8) ? 1 : 40 + i * 3 + j), 1'b1);

    for (int i = 0; i < 8; i++) issue(badkeys[i], $urandom_range(0, 100), 1'b1);

    issue(5'h1B, 200, 1'b0);
    repeat (40) tick();
    do_reset(2);
    issue(5'h1B, 30, 1'b1);

    repeat (30) issue(5'($urandom), $urandom_range(0, 100), 1'b1);

    repeat (5) tick();
    check("queue_drained", 0, q0.size(), 0);
    check("queue_drained", 1, q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
